// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I definitions used by the instruction encoder and decoder.
//   inst_t    - instruction format selector (R, I, S, SB, UJ, U); 6 and 7 are illegal
//   OP_*      - major opcode constants for the base integer ISA
//   fmt_legal - true when a raw 3-bit format code names a real format
package rv32_pkg;

  typedef enum logic [2:0] {
    R  = 3'd0,
    I  = 3'd1,
    S  = 3'd2,
    SB = 3'd3,
    UJ = 3'd4,
    U  = 3'd5
  } inst_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  function automatic logic fmt_legal(input logic [2:0] fmt);
    return fmt <= 3'(U);
  endfunction

endpackage

// File: rtl/inst_fifo2.sv
// inst_fifo2: two-entry, 32-bit first-word-fall-through FIFO.
//   clk, nrst  - clock, asynchronous active-low reset (empties the FIFO)
//   flush      - synchronous clear; wins over a simultaneous push and pop
//   in_valid / in_ready / in_data    - write side, in_ready = (count < 2)
//   out_valid / out_ready / out_data - read side, out_data is the head entry
module inst_fifo2 (
  input  logic        clk,
  input  logic        nrst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  logic [31:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  count;
  logic        do_push;
  logic        do_pop;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];

  assign do_push = in_valid  && in_ready  && !flush;
  assign do_pop  = out_valid && out_ready && !flush;

  // NOTE: the two storage words are reset along with the pointers; at this size it
  // is cheap and it makes out_data read as zero after reset instead of X.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Simultaneous push and pop leaves the count unchanged.
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32I fields into 32-bit instruction words, buffers them
// in a 2-entry FIFO and emits each with a sequential word address.
//   clk, nrst          - clock, asynchronous active-low reset
//   flush              - sync clear of FIFO, address counter and err
//   in_valid/in_ready  - field-set handshake
//   in_type            - format code (inst_t); 6 and 7 are accepted but flagged in err
//   in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm - decoded fields
//   out_valid/out_ready, out_inst, out_addr - encoded word stream
//   err                - sticky illegal-format flag
module inst_encoder
  import rv32_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_type,
  input  logic [6:0]        in_opcode,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err
);

  logic [31:0]       enc_word;
  logic              enc_legal;
  logic              accept;
  logic              pop;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  // NOTE: every output of this block gets a default first, so no path through the
  // case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    enc_word  = '0;
    enc_legal = fmt_legal(in_type);
    case (in_type)
      R:  enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      I:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      SB: enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
      UJ: enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                      in_rd, in_opcode};
      U:  enc_word = {in_imm[31:12], in_rd, in_opcode};
      default: enc_word = '0;
    endcase
  end

  // An illegal set still completes its handshake; it just never reaches the FIFO.
  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  inst_fifo2 u_fifo (
    .clk       (clk),
    .nrst      (nrst),
    .flush     (flush),
    .in_valid  (in_valid && enc_legal),
    .in_ready  (in_ready),
    .in_data   (enc_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_inst)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else if (flush) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      if (pop) begin
        addr_q <= addr_q + 1'b1;   // natural wrap at 2**ADDR_W
      end
      if (accept && !enc_legal) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_addr = addr_q;
  assign err      = err_q;

endmodule
